// File: rtl/k12a_lcd_sequencer.sv
// HD44780-style LCD transfer sequencer: buffers CPU-written bytes, runs the
// power-on init sequence and generates setup/enable/hold and execution waits.
module k12a_lcd_sequencer #(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned SETUP_CYCLES     = 2,
  parameter int unsigned PULSE_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES      = 2,
  parameter int unsigned CMD_WAIT_CYCLES  = 40,
  parameter int unsigned LONG_WAIT_CYCLES = 1600,
  parameter int unsigned INIT_WAIT_CYCLES = 15000
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       clear_overflow,
  output logic       fifo_full,
  output logic       busy,
  output logic       init_done,
  output logic       overflow,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_B = (HOLD_CYCLES > CMD_WAIT_CYCLES) ? HOLD_CYCLES : CMD_WAIT_CYCLES;
  localparam int unsigned MAX_C = (LONG_WAIT_CYCLES > INIT_WAIT_CYCLES) ? LONG_WAIT_CYCLES : INIT_WAIT_CYCLES;
  localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_ALL = (MAX_C > MAX_D) ? MAX_C : MAX_D;
  localparam int unsigned CW = $clog2(MAX_ALL + 1);
  localparam logic [2:0] INIT_LEN = 3'd5;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      init_idx;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  logic            fifo_empty;
  logic            push_ok;
  logic            pop;
  logic            src_valid;
  logic [8:0]      src;
  logic            launch;
  logic            cnt_last;
  logic            long_wait;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    init_rom = 8'h38;
      3'd1:    init_rom = 8'h38;
      3'd2:    init_rom = 8'h0C;
      3'd3:    init_rom = 8'h01;
      3'd4:    init_rom = 8'h06;
      default: init_rom = 8'h00;
    endcase
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign busy       = !init_done || !fifo_empty || (state != S_IDLE);
  assign lcd_rw     = 1'b0;
  assign cnt_last   = (cnt == CW'(1));

  // Clear (01) and home (02/03) need the long execution time.
  assign long_wait  = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data != 8'h00);

  always_comb begin
    src_valid = 1'b0;
    src       = '0;
    if (!init_done) begin
      src_valid = (init_idx < INIT_LEN);
      src       = {1'b0, init_rom(init_idx)};
    end else begin
      src_valid = !fifo_empty;
      src       = mem[rd_ptr];
    end
  end

  // Full is judged before any pop, so a push into a full FIFO is always dropped.
  assign launch  = (state == S_IDLE) && src_valid;
  assign pop     = launch && init_done;
  assign push_ok = wr_valid && !fifo_full;

  always_ff @(posedge cpu_clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= {wr_rs, wr_data};
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (wr_valid && fifo_full) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT_WAIT;
      cnt       <= CW'(INIT_WAIT_CYCLES);
      init_idx  <= '0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      case (state)
        S_INIT_WAIT: begin
          if (cnt_last) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_IDLE: begin
          if (launch) begin
            lcd_rs   <= src[8];
            lcd_data <= src[7:0];
            if (!init_done) begin
              init_idx <= init_idx + 3'd1;
            end
            state <= S_SETUP;
            cnt   <= CW'(SETUP_CYCLES);
          end
        end
        S_SETUP: begin
          if (cnt_last) begin
            state  <= S_PULSE;
            lcd_en <= 1'b1;
            cnt    <= CW'(PULSE_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt_last) begin
            state  <= S_HOLD;
            lcd_en <= 1'b0;
            cnt    <= CW'(HOLD_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_last) begin
            state <= S_EXEC_WAIT;
            cnt   <= long_wait ? CW'(LONG_WAIT_CYCLES) : CW'(CMD_WAIT_CYCLES);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_EXEC_WAIT: begin
          if (cnt_last) begin
            state <= S_IDLE;
            if (!init_done && (init_idx == INIT_LEN)) begin
              init_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state  <= S_INIT_WAIT;
          cnt    <= CW'(INIT_WAIT_CYCLES);
          lcd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_lcd_sequencer.sv
// Directed bench for k12a_lcd_sequencer with shortened timing parameters.
module tb_k12a_lcd_sequencer;

  logic       cpu_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       wr_valid  = 1'b0;
  logic       wr_rs     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       clear_overflow = 1'b0;
  logic       fifo_full, busy, init_done, overflow, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  // Pulse log filled by the monitor: one entry per lcd_en high period.
  int unsigned cyc = 0;
  int          np  = 0;
  logic [7:0]  p_data   [64];
  logic        p_rs     [64];
  int unsigned p_rise   [64];
  int unsigned p_width  [64];
  logic        p_stable [64];

  k12a_lcd_sequencer #(
    .FIFO_DEPTH      (4),
    .SETUP_CYCLES    (2),
    .PULSE_CYCLES    (4),
    .HOLD_CYCLES     (2),
    .CMD_WAIT_CYCLES (5),
    .LONG_WAIT_CYCLES(20),
    .INIT_WAIT_CYCLES(10)
  ) dut (
    .cpu_clock     (cpu_clock),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_rs         (wr_rs),
    .wr_data       (wr_data),
    .clear_overflow(clear_overflow),
    .fifo_full     (fifo_full),
    .busy          (busy),
    .init_done     (init_done),
    .overflow      (overflow),
    .lcd_rs        (lcd_rs),
    .lcd_rw        (lcd_rw),
    .lcd_en        (lcd_en),
    .lcd_data      (lcd_data)
  );

  always #5 cpu_clock = ~cpu_clock;

  always @(posedge cpu_clock) cyc <= cyc + 1;

  initial begin : monitor
    logic en_q;
    en_q = 1'b0;
    forever begin
      @(negedge cpu_clock);
      if (np < 64) begin
        if (lcd_en && !en_q) begin
          p_data[np]   = lcd_data;
          p_rs[np]     = lcd_rs;
          p_rise[np]   = cyc;
          p_width[np]  = 0;
          p_stable[np] = 1'b1;
        end
        if (lcd_en) begin
          p_width[np] = p_width[np] + 1;
          if (lcd_data !== p_data[np] || lcd_rs !== p_rs[np]) p_stable[np] = 1'b0;
        end
        if (!lcd_en && en_q) np = np + 1;
      end
      en_q = lcd_en;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge cpu_clock);
    @(negedge cpu_clock);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge cpu_clock);
    reset_n = 1'b0;
    #1;
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", lcd_en); end
    checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
    checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    tick();
    tick();
  endtask

  task automatic test_init();
    logic [7:0] rom [5];
    int unsigned gap [4];
    int base;
    bit ok;
    rom[0] = 8'h38; rom[1] = 8'h38; rom[2] = 8'h0C; rom[3] = 8'h01; rom[4] = 8'h06;
    gap[0] = 14; gap[1] = 14; gap[2] = 14; gap[3] = 29;
    base = np;
    reset_n = 1'b1;
    wait_idle(400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_timeout: got busy %b expected 0 within budget", busy); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b expected 1", init_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b expected 0", busy); end
    checks++; if (np - base !== 5) begin errors++; $display("FAIL init_count: got %0d pulses expected 5", np - base); end
    if (np - base == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (p_data[base+i] !== rom[i]) begin errors++; $display("FAIL init_data[%0d]: got %h expected %h", i, p_data[base+i], rom[i]); end
        checks++; if (p_rs[base+i] !== 1'b0) begin errors++; $display("FAIL init_rs[%0d]: got %b expected 0", i, p_rs[base+i]); end
        checks++; if (p_width[base+i] !== 4) begin errors++; $display("FAIL init_width[%0d]: got %0d expected 4", i, p_width[base+i]); end
        checks++; if (p_stable[base+i] !== 1'b1) begin errors++; $display("FAIL init_stable[%0d]: got %b expected 1", i, p_stable[base+i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (p_rise[base+i+1] - p_rise[base+i] !== gap[i]) begin
          errors++;
          $display("FAIL init_gap[%0d]: got %0d expected %0d", i, p_rise[base+i+1] - p_rise[base+i], gap[i]);
        end
      end
    end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    tick();
    wr_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_n: got %b expected 1", busy); end
    checks++; if (lcd_data !== 8'h06) begin errors++; $display("FAIL single_data_n: got %h expected 06", lcd_data); end
    tick();
    checks++; if (lcd_data !== 8'h41) begin errors++; $display("FAIL single_data_n1: got %h expected 41", lcd_data); end
    checks++; if (lcd_rs !== 1'b1) begin errors++; $display("FAIL single_rs_n1: got %b expected 1", lcd_rs); end
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL single_en_n1: got %b expected 0", lcd_en); end
    for (int k = 2; k <= 7; k++) begin
      logic exp_en;
      tick();
      exp_en = (k >= 3 && k <= 6);
      checks++; if (lcd_en !== exp_en) begin errors++; $display("FAIL single_en_n%0d: got %b expected %b", k, lcd_en, exp_en); end
    end
    for (int k = 8; k <= 13; k++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_n13: got %b expected 1", busy); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_n15: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    base = np;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
    clear_overflow = 1'b1;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
    tick();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2: got %b expected 0", overflow); end
    for (int k = 9; k <= 14; k++) tick();
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full_n14: got %b expected 1", fifo_full); end
    // Edge N+15 pops the head while this push targets the still-full FIFO.
    wr_valid = 1'b1; wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pop_push: got %b expected 1", overflow); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full_after_pop: got %b expected 0", fifo_full); end
    wait_idle(300, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_timeout: got busy %b expected 0 within budget", busy); end
    checks++; if (np - base !== 5) begin errors++; $display("FAIL ovf_count: got %0d pulses expected 5", np - base); end
    if (np - base == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (p_data[base+i] !== 8'h10 + 8'(i)) begin
          errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, p_data[base+i], 8'h10 + 8'(i));
        end
      end
      checks++; if (p_rise[base+1] - p_rise[base] !== 14) begin errors++; $display("FAIL ovf_spacing: got %0d expected 14", p_rise[base+1] - p_rise[base]); end
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
  endtask

  task automatic test_early_push();
    logic [7:0] ed [3];
    logic       er [3];
    int base;
    bit ok;
    ed[0] = 8'hA1; er[0] = 1'b1;
    ed[1] = 8'h80; er[1] = 1'b0;
    ed[2] = 8'hA3; er[2] = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    base = np;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_rs = er[i]; wr_data = ed[i];
      tick();
    end
    wr_valid = 1'b0;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL early_init_done: got %b expected 0", init_done); end
    wait_idle(500, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL early_timeout: got busy %b expected 0 within budget", busy); end
    checks++; if (np - base !== 8) begin errors++; $display("FAIL early_count: got %0d pulses expected 8", np - base); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL early_overflow: got %b expected 0", overflow); end
    if (np - base == 8) begin
      checks++; if (p_data[base+4] !== 8'h06) begin errors++; $display("FAIL early_last_init: got %h expected 06", p_data[base+4]); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (p_data[base+5+i] !== ed[i]) begin errors++; $display("FAIL early_data[%0d]: got %h expected %h", i, p_data[base+5+i], ed[i]); end
        checks++; if (p_rs[base+5+i] !== er[i]) begin errors++; $display("FAIL early_rs[%0d]: got %b expected %b", i, p_rs[base+5+i], er[i]); end
        checks++; if (p_rise[base+5+i] - p_rise[base+4+i] !== 14) begin errors++; $display("FAIL early_gap[%0d]: got %0d expected 14", i, p_rise[base+5+i] - p_rise[base+4+i]); end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int base;
    int unsigned rel;
    bit ok;
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
    tick();
    wr_data = 8'h66;
    tick();
    wr_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lcd_en) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_en_timeout: got en %b expected 1 within budget", lcd_en); end
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL mid_en_async: got %b expected 0", lcd_en); end
    checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", lcd_data); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b expected 0", init_done); end
    tick();
    tick();
    base = np;
    rel = cyc;
    reset_n = 1'b1;
    wait_idle(400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_timeout: got busy %b expected 0 within budget", busy); end
    checks++; if (np - base !== 5) begin errors++; $display("FAIL mid_count: got %0d pulses expected 5", np - base); end
    if (np - base == 5) begin
      checks++; if (p_rise[base] - rel !== 13) begin errors++; $display("FAIL mid_first_rise: got %0d expected 13", p_rise[base] - rel); end
      checks++; if (p_data[base+4] !== 8'h06) begin errors++; $display("FAIL mid_last_data: got %h expected 06", p_data[base+4]); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_overflow();
    test_early_push();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/k12a_lcd_sequencer.md
Name: k12a_lcd_sequencer

Overview:
Autonomous HD44780-style LCD transfer sequencer that sits between the I/O block's LCD store path and the LCD pins. It replaces software-timed enable strobing with hardware timing.
- Buffers CPU-written command/data bytes in a small FIFO.
- Runs the power-on initialisation sequence.
- Generates setup/enable/hold timing and per-command execution waits.
- Exposes busy/full status for the control register read path.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2
SETUP_CYCLES, 2, cycles lcd_rs/lcd_data are stable before lcd_en rises; >=1
PULSE_CYCLES, 4, cycles lcd_en is high; >=1
HOLD_CYCLES, 2, cycles lcd_rs/lcd_data are held after lcd_en falls; >=1
CMD_WAIT_CYCLES, 40, post-transfer wait for normal commands and data; >=1
LONG_WAIT_CYCLES, 1600, post-transfer wait for clear/home commands; >=1
INIT_WAIT_CYCLES, 15000, power-on delay before the first init command; >=1

Ports:
cpu_clock  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  one-cycle push strobe (from lcd_data_store)
wr_rs  in  1  register select for pushed byte (0 instruction, 1 data)
wr_data  in  8  byte to push
clear_overflow  in  1  clears overflow flag
fifo_full  out  1  FIFO count == FIFO_DEPTH
busy  out  1  !init_done | FIFO non-empty | state != IDLE
init_done  out  1  init sequence complete (sticky until reset)
overflow  out  1  sticky: a push was dropped
lcd_rs  out  1  registered register select
lcd_rw  out  1  constant 0 (write only)
lcd_en  out  1  registered enable strobe
lcd_data  out  8  registered data bus

Behaviour:
- Reset (async, reset_n low):
  - Outputs: lcd_rs=0, lcd_en=0, lcd_data=8'h00, init_done=0, overflow=0.
  - FIFO empty; init index=0; state=INIT_WAIT; counter loaded with INIT_WAIT_CYCLES.
  - Reset mid-transfer aborts immediately: lcd_en drops asynchronously and the FIFO is discarded.
- States: INIT_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC_WAIT. A single down-counter times each state; a state exits on the edge where its counter reaches 1.
- INIT_WAIT:
  - Lasts INIT_WAIT_CYCLES cycles, then goes to IDLE.
  - Init ROM, all rs=0, in order: 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06.
- IDLE, source selection:
  - While !init_done, the source is init ROM[index].
  - Otherwise the source is the FIFO head, if the FIFO is non-empty.
- IDLE, on a valid source at an edge:
  - Load lcd_rs/lcd_data.
  - Pop the FIFO, or increment the init index.
  - Go to SETUP.
  - When the index passes the last ROM entry, init_done=1 on the edge that enters IDLE after that entry's EXEC_WAIT.
- Transfer sequence:
  - SETUP: SETUP_CYCLES cycles, lcd_en=0.
  - PULSE: PULSE_CYCLES cycles, lcd_en=1.
  - HOLD: HOLD_CYCLES cycles, lcd_en=0.
  - EXEC_WAIT: wait, then IDLE. lcd_en is registered, so it is high for exactly PULSE_CYCLES consecutive cycles.
- EXEC_WAIT length: LONG_WAIT_CYCLES if rs=0 and data[7:2]==0 and data!=0 (clear 8'h01, home 8'h02/8'h03); otherwise CMD_WAIT_CYCLES.
- lcd_rs/lcd_data are stable from the SETUP entry until the next IDLE->SETUP load; they are not cleared between transfers.
- Latency: a push at edge N into an empty FIFO while in IDLE with init_done:
  - lcd_data changes at edge N+1.
  - lcd_en rises at edge N+1+SETUP_CYCLES.
  - busy is high from edge N.
- Back-to-back: the minimum spacing of lcd_en rising edges is SETUP+PULSE+HOLD+wait+1 cycles (the +1 is the IDLE cycle).
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers and wrap-around; the count is 0..FIFO_DEPTH.
  - Pushes are accepted during INIT_WAIT and init; they are drained only after init_done.
- Full FIFO:
  - A push when fifo_full is dropped and sets overflow, even if a pop occurs the same cycle (full is evaluated pre-pop).
  - A push with a simultaneous pop when not full leaves count unchanged and stores the entry.
- Overflow flag: a simultaneous clear_overflow and dropped push leaves overflow=1 (set wins).
- A push while empty with a simultaneous IDLE check does not bypass: the entry is stored and popped the next cycle.

Test Plan:
- Bench overrides: INIT_WAIT=10, CMD_WAIT=5, LONG_WAIT=20, SETUP=2, PULSE=4, HOLD=2.
- Init: release reset, no pushes -> five lcd_en pulses of 4 cycles each, data 38,38,0C,01,06, rs=0. The gap after 01 is 20 wait cycles; the others are 5. Then init_done=1, busy=0.
- Single data write after init: push rs=1 data=8'h41 at edge N -> lcd_data=41, lcd_rs=1 at N+1; lcd_en high edges N+3..N+6; busy low at N+1+2+4+2+5+1.
- Early pushes: push 3 bytes during INIT_WAIT -> all are held until after the 06 init transfer, then emitted in order; overflow=0.
- Overflow: push 6 bytes on consecutive cycles after init -> first 4 bytes are... see next line.
  - One entry is popped at N+1 (capacity frees one slot), so exactly 5 bytes are accepted and emitted in order.
  - The 6th push is dropped and overflow=1.
  - clear_overflow -> overflow=0.
- Simultaneous set/clear: push to a full FIFO with clear_overflow the same cycle -> overflow=1.
- Reset mid-PULSE: assert reset_n low while lcd_en=1 -> lcd_en=0 immediately, FIFO empty, state restarts INIT_WAIT, init_done=0.
